// File: rtl/cw_pkg.sv
// rtl/cw_pkg.sv - shared widths and FSM state encoding for the codeword encoder control
package cw_pkg;

    localparam int N_W = 19;
    localparam int T_W = 4;
    localparam int D_W = 18;
    localparam int U_W = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_D = 3'd1,
        FLAG   = 3'd2,
        INDEX  = 3'd3,
        EMIT   = 3'd4,
        FILL   = 3'd5,
        FIN    = 3'd6
    } state_t;

endpackage

// File: rtl/cw_encode_ctrl_if.sv
// rtl/cw_encode_ctrl_if.sv - control, message-bit, best-d and delta signals of cw_encode_ctrl
// CW_ENC_BITCNT_EN adds the bits_used counter output.
interface cw_encode_ctrl_if;
    import cw_pkg::*;

    logic           start;
    logic [N_W-1:0] n_init;
    logic [T_W-1:0] t_init;
    logic           bit_in;
    logic           bit_valid;
    logic           bit_ready;
    logic [N_W-1:0] n_q;
    logic [T_W-1:0] t_q;
    logic [D_W-1:0] d;
    logic [U_W-1:0] u;
    logic [D_W-1:0] delta;
    logic           delta_valid;
    logic           delta_ready;
    logic           busy;
    logic           done;
    logic           err;
`ifdef CW_ENC_BITCNT_EN
    logic [15:0]    bits_used;
`endif

    modport master (
        output start, n_init, t_init, bit_in, bit_valid, d, u, delta_ready,
        input  bit_ready, n_q, t_q, delta, delta_valid, busy, done, err
`ifdef CW_ENC_BITCNT_EN
        , input bits_used
`endif
    );

    modport slave (
        input  start, n_init, t_init, bit_in, bit_valid, d, u, delta_ready,
        output bit_ready, n_q, t_q, delta, delta_valid, busy, done, err
`ifdef CW_ENC_BITCNT_EN
        , output bits_used
`endif
    );

endinterface

// File: rtl/cw_idx_shreg.sv
// rtl/cw_idx_shreg.sv - u-bit MSB-first index collector with remaining-bit counter
module cw_idx_shreg
    import cw_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [U_W-1:0] len,
    input  logic           shift,
    input  logic           bit_in,
    output logic [D_W-1:0] idx,
    output logic           last
);

    logic [D_W-1:0] idx_r;
    logic [U_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r <= '0;
            cnt   <= '0;
        end else if (load) begin
            idx_r <= '0;
            cnt   <= len;
        end else if (shift) begin
            idx_r <= {idx_r[D_W-2:0], bit_in};
            cnt   <= cnt - 1'b1;
        end
    end

    // High while the bit about to be shifted in is the final index bit.
    assign last = (cnt == U_W'(1));
    assign idx  = idx_r;

endmodule

// File: rtl/cw_encode_ctrl.sv
// rtl/cw_encode_ctrl.sv - serial-bit to position-gap encoder control FSM (CW_ENC_BITCNT_EN: bits_used counter)
module cw_encode_ctrl
    import cw_pkg::*;
#(
    parameter int BD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    cw_encode_ctrl_if.slave bus
);

    localparam int WC_W = $clog2(BD_LAT + 2);

    state_t         state;
    logic [N_W-1:0] n_r;
    logic [T_W-1:0] t_r;
    logic [D_W-1:0] d_r;
    logic [U_W-1:0] u_r;
    logic [WC_W-1:0] wait_cnt;
    logic           err_r;
    logic           done_r;
    logic [D_W-1:0] idx;
    logic           idx_last;
    logic           bit_ready;
    logic           delta_valid;
    logic           bit_hs;
    logic           delta_hs;
    logic           idx_load;
    logic           idx_shift;
    logic [N_W-1:0] t_ext;
    logic [N_W-1:0] d_ext;

    assign bit_ready   = (state == FLAG) || (state == INDEX);
    assign delta_valid = (state == EMIT) || (state == FILL);
    assign bit_hs      = bit_ready && bus.bit_valid;
    assign delta_hs    = delta_valid && bus.delta_ready;
    assign idx_load    = (state == FLAG) && bit_hs && !bus.bit_in;
    assign idx_shift   = (state == INDEX) && bit_hs;
    assign t_ext       = N_W'(t_r);
    assign d_ext       = N_W'(d_r);

    cw_idx_shreg u_idx (
        .clk    (clk),
        .rst    (rst),
        .load   (idx_load),
        .len    (u_r),
        .shift  (idx_shift),
        .bit_in (bus.bit_in),
        .idx    (idx),
        .last   (idx_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            n_r      <= '0;
            t_r      <= '0;
            d_r      <= '0;
            u_r      <= '0;
            wait_cnt <= '0;
            err_r    <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= (state == FIN);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_r      <= bus.n_init;
                        t_r      <= bus.t_init;
                        err_r    <= 1'b0;
                        wait_cnt <= '0;
                        state    <= (bus.t_init == '0) ? FIN : WAIT_D;
                    end
                end
                // Every entry here follows an n/t update; give the best-d stage time to settle.
                WAIT_D: begin
                    if (wait_cnt == WC_W'(BD_LAT)) begin
                        wait_cnt <= '0;
                        d_r      <= bus.d;
                        u_r      <= bus.u;
                        if (t_r == '0) begin
                            state <= FIN;
                        end else if (n_r == t_ext) begin
                            state <= FILL;
                        end else if (n_r < t_ext) begin
                            err_r <= 1'b1;
                            state <= FIN;
                        end else begin
                            state <= FLAG;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                FLAG: begin
                    if (bit_hs) begin
                        if (bus.bit_in) begin
                            if (d_ext >= n_r) begin
                                err_r <= 1'b1;
                                state <= FIN;
                            end else begin
                                n_r   <= n_r - d_ext;
                                state <= WAIT_D;
                            end
                        end else begin
                            state <= INDEX;
                        end
                    end
                end
                INDEX: begin
                    if (idx_shift && idx_last) begin
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (delta_hs) begin
                        n_r   <= n_r - (N_W'(idx) + N_W'(1));
                        t_r   <= t_r - 1'b1;
                        state <= WAIT_D;
                    end
                end
                FILL: begin
                    if (delta_hs) begin
                        n_r <= n_r - 1'b1;
                        t_r <= t_r - 1'b1;
                        if (t_r == T_W'(1)) begin
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CW_ENC_BITCNT_EN
    logic [15:0] bits_used_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_used_r <= '0;
        end else if ((state == IDLE) && bus.start) begin
            bits_used_r <= '0;
        end else if (bit_hs && (bits_used_r != 16'hFFFF)) begin
            bits_used_r <= bits_used_r + 1'b1;
        end
    end

    assign bus.bits_used = bits_used_r;
`endif

    assign bus.bit_ready   = bit_ready;
    assign bus.delta_valid = delta_valid;
    assign bus.delta       = (state == EMIT) ? idx : '0;
    assign bus.n_q         = n_r;
    assign bus.t_q         = t_r;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_r;
    assign bus.err         = err_r;

endmodule

// File: tb/tb_cw_encode_ctrl.sv
// tb/tb_cw_encode_ctrl.sv - table-driven and directed-sequence bench for cw_encode_ctrl
module tb_cw_encode_ctrl;
    import cw_pkg::*;

    typedef struct {
        logic [18:0] n;
        logic [3:0]  t;
        logic [17:0] d;
        logic [4:0]  u;
        logic [31:0] bits;
        int          nb;
        logic [18:0] exp_n;
        logic [3:0]  exp_t;
        int          exp_nd;
        logic [17:0] exp_last;
        logic        exp_err;
        logic        exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_dl = 0;
    int   n_bits = 0;
    int   n_done = 0;
    int   n_brhi = 0;
    logic [17:0] last_dl = '0;
    vec_t vecs [9];

    always #5 clk = ~clk;

    cw_encode_ctrl_if bus ();

    cw_encode_ctrl #(.BD_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.delta_valid && bus.delta_ready) begin
                n_dl    <= n_dl + 1;
                last_dl <= bus.delta;
            end
            if (bus.bit_valid && bus.bit_ready) n_bits <= n_bits + 1;
            if (bus.bit_ready) n_brhi <= n_brhi + 1;
            if (bus.done) n_done <= n_done + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        bus.n_init = '0;
        bus.t_init = '0;
        bus.bit_in = 1'b0;
        bus.bit_valid = 1'b0;
        bus.d = '0;
        bus.u = '0;
        bus.delta_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [18:0] n, input logic [3:0] t);
        @(negedge clk);
        bus.n_init = n;
        bus.t_init = t;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int nb);
        int w;
        for (int i = nb - 1; i >= 0; i--) begin
            bus.bit_in = bits[i];
            bus.bit_valid = 1'b1;
            w = 0;
            while (!bus.bit_ready && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) begin
                checks++;
                errors++;
                $display("FAIL bit_wait actual=timeout required=bit_ready");
                break;
            end
            @(negedge clk);
        end
        bus.bit_valid = 1'b0;
    endtask

    task automatic settle(output logic done_seen);
        int w;
        w = 0;
        while (!(bus.bit_ready || bus.done) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            checks++;
            errors++;
            $display("FAIL settle actual=timeout required=bit_ready_or_done");
        end
        done_seen = bus.done;
    endtask

    initial begin
        logic done_seen;
        int   nd0;
        int   nb0;
        int   nr0;
        int   w;

        //          n        t     d        u     bits            nb  exp_n    exp_t nd last    err   done
        vecs[0] = '{19'd1024, 4'd2, 18'd256, 5'd8, 32'b1,          1, 19'd768,  4'd2, 0, 18'd0, 1'b0, 1'b0};
        vecs[1] = '{19'd1024, 4'd2, 18'd256, 5'd8, 32'b000000101,  9, 19'd1018, 4'd1, 1, 18'd5, 1'b0, 1'b0};
        vecs[2] = '{19'd4,    4'd4, 18'd0,   5'd0, 32'b0,          0, 19'd0,    4'd0, 4, 18'd0, 1'b0, 1'b1};
        vecs[3] = '{19'd3,    4'd5, 18'd0,   5'd0, 32'b0,          0, 19'd3,    4'd5, 0, 18'd0, 1'b1, 1'b1};
        vecs[4] = '{19'd100,  4'd1, 18'd64,  5'd6, 32'b11,         2, 19'd36,   4'd1, 0, 18'd0, 1'b1, 1'b1};
        vecs[5] = '{19'd20,   4'd2, 18'd4,   5'd2, 32'b011010,     6, 19'd13,   4'd0, 2, 18'd2, 1'b0, 1'b1};
        vecs[6] = '{19'd50,   4'd0, 18'd0,   5'd0, 32'b0,          0, 19'd50,   4'd0, 0, 18'd0, 1'b0, 1'b1};
        vecs[7] = '{19'd5,    4'd3, 18'd4,   5'd2, 32'b1,          1, 19'd1,    4'd3, 0, 18'd0, 1'b1, 1'b1};
        vecs[8] = '{19'd6,    4'd2, 18'd4,   5'd2, 32'b000,        3, 19'd5,    4'd1, 1, 18'd0, 1'b0, 1'b0};

        do_reset();
        chk("rst_busy", bus.busy, 0);
        chk("rst_n_q", bus.n_q, 0);
        chk("rst_t_q", bus.t_q, 0);
        chk("rst_delta", bus.delta, 0);
        chk("rst_delta_valid", bus.delta_valid, 0);
        chk("rst_bit_ready", bus.bit_ready, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            bus.d = vecs[i].d;
            bus.u = vecs[i].u;
            bus.delta_ready = 1'b1;
            nd0 = n_dl;
            pulse_start(vecs[i].n, vecs[i].t);
            if (vecs[i].nb > 0) send_bits(vecs[i].bits, vecs[i].nb);
            settle(done_seen);
            chk($sformatf("v%0d_n_q", i), bus.n_q, vecs[i].exp_n);
            chk($sformatf("v%0d_t_q", i), bus.t_q, vecs[i].exp_t);
            chk($sformatf("v%0d_deltas", i), n_dl - nd0, vecs[i].exp_nd);
            if (vecs[i].exp_nd > 0) chk($sformatf("v%0d_last_delta", i), last_dl, vecs[i].exp_last);
            chk($sformatf("v%0d_err", i), bus.err, vecs[i].exp_err);
            chk($sformatf("v%0d_done", i), done_seen, vecs[i].exp_done);
`ifdef CW_ENC_BITCNT_EN
            chk($sformatf("v%0d_bits_used", i), bus.bits_used, vecs[i].nb);
`endif
        end

        // t=0 start: FIN one cycle after the start edge, registered done the cycle after that.
        do_reset();
        nd0 = n_dl;
        nr0 = n_brhi;
        pulse_start(19'd9, 4'd0);
        chk("t0_done_early", bus.done, 0);
        chk("t0_busy_fin", bus.busy, 1);
        @(negedge clk);
        chk("t0_done", bus.done, 1);
        chk("t0_busy_idle", bus.busy, 0);
        @(negedge clk);
        chk("t0_done_pulse", bus.done, 0);
        chk("t0_no_bit_ready", n_brhi - nr0, 0);
        chk("t0_no_delta", n_dl - nd0, 0);

        // Back-pressure in EMIT, start ignored while busy, then reset mid-INDEX.
        do_reset();
        bus.d = 18'd256;
        bus.u = 5'd8;
        pulse_start(19'd1024, 4'd2);
        send_bits(32'b000000101, 9);
        w = 0;
        while (!bus.delta_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        bus.bit_valid = 1'b1;
        bus.bit_in = 1'b1;
        nb0 = n_bits;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_valid", k), bus.delta_valid, 1);
            chk($sformatf("stall%0d_delta", k), bus.delta, 5);
            @(negedge clk);
        end
        chk("stall_no_bits", n_bits - nb0, 0);
        chk("stall_n_q", bus.n_q, 1024);
        bus.bit_valid = 1'b0;
        bus.delta_ready = 1'b1;
        @(negedge clk);
        chk("stall_accept_valid", bus.delta_valid, 0);
        chk("stall_accept_n_q", bus.n_q, 1018);
        chk("stall_accept_t_q", bus.t_q, 1);
        pulse_start(19'd7, 4'd1);
        chk("busy_start_n_q", bus.n_q, 1018);
        chk("busy_start_t_q", bus.t_q, 1);
        send_bits(32'b0101, 4);
        chk("index_bit_ready", bus.bit_ready, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_n_q", bus.n_q, 0);
        chk("mid_rst_t_q", bus.t_q, 0);
        chk("mid_rst_delta", bus.delta, 0);
        chk("mid_rst_delta_valid", bus.delta_valid, 0);
        chk("mid_rst_bit_ready", bus.bit_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        nd0 = n_dl;
        nr0 = n_done;
        repeat (20) @(negedge clk);
        chk("post_rst_no_delta", n_dl - nd0, 0);
        chk("post_rst_no_done", n_done - nr0, 0);
        chk("post_rst_idle", bus.busy, 0);

        // err stays set in IDLE and clears on the next accepted start.
        do_reset();
        pulse_start(19'd3, 4'd5);
        settle(done_seen);
        repeat (3) @(negedge clk);
        chk("err_sticky", bus.err, 1);
        bus.d = 18'd256;
        bus.u = 5'd8;
        pulse_start(19'd1024, 4'd2);
        chk("err_cleared", bus.err, 0);
        chk("restart_busy", bus.busy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cw_encode_ctrl.md
CW_ENCODE_CTRL -- requirements
Module: cw_encode_ctrl

Interface
REQ-001 Parameter BD_LAT, default 2: cycles from a stable n_q/t_q to valid d/u.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; loads n_init/t_init, accepted only in IDLE.
REQ-005 n_init  in  19, t_init  in  4: initial length and weight.
REQ-006 bit_in, bit_valid  in  1 each; bit_ready  out  1: serial message bits, MSB first.
REQ-007 n_q  out  19, t_q  out  4: current n/t, wired to the best-d stage.
REQ-008 d  in  18, u  in  5: best-d result, d = 2^u.
REQ-009 delta  out  18, delta_valid  out  1, delta_ready  in  1: emitted position gap.
REQ-010 busy, done, err  out  1 each.

Function
REQ-011 FSM states SHALL be: IDLE, WAIT_D, FLAG, INDEX, EMIT, FILL, FIN.
REQ-012 IDLE: start loads n_q, t_q and goes to WAIT_D, or to FIN if t_init==0.
REQ-013 WAIT_D: count BD_LAT+1 cycles after any n_q/t_q change, then latch d/u into d_r/u_r.
REQ-014 WAIT_D exit: t_q==0 -> FIN; n_q==t_q -> FILL; n_q<t_q -> err=1, then FIN; else FLAG.
REQ-015 FLAG: bit_ready=1; consume one bit on bit_valid&bit_ready.
REQ-016 FLAG, bit 1: if d_r>=n_q then err=1 and FIN; else n_q-=d_r and go to WAIT_D.
REQ-017 FLAG, bit 0: clear the index register, load a counter with u_r, go to INDEX.
REQ-018 INDEX: bit_ready=1; shift in u_r bits MSB first, one per handshake, then go to EMIT.
REQ-019 INDEX with u_r==0 is impossible (u>=2); no special case.
REQ-020 EMIT: delta=idx, delta_valid=1, held stable until delta_ready.
REQ-021 EMIT on accept: n_q-=idx+1, t_q-=1, go to WAIT_D.
REQ-022 FILL: emit t_q deltas of 0, each under the EMIT handshake, decrementing n_q and t_q; then FIN.
REQ-023 FIN: done=1 for one cycle, then IDLE.
REQ-024 bit_ready=0 outside FLAG/INDEX; delta_valid=0 outside EMIT/FILL.
REQ-025 busy=1 in every state except IDLE.
REQ-026 start outside IDLE is ignored.
REQ-027 err is sticky until the next accepted start.
REQ-028 Arithmetic is unsigned, 19 bits. idx+1 is computed at 19 bits. Subtraction never wraps because of the checks in REQ-014/REQ-016.
REQ-029 Latency from bit 0 to delta_valid: 1+u_r handshake cycles plus one cycle.

Reset
REQ-030 rst SHALL force IDLE, n_q=0, t_q=0, delta=0, all strobes 0, err=0, counters 0.
REQ-031 rst mid-operation SHALL abandon the word; no delta or done is issued afterwards.

Configuration
REQ-032 With CW_ENC_BITCNT_EN defined: output bits_used [15:0] counts consumed message bits, clears on start, saturates at 0xFFFF.
REQ-033 Without CW_ENC_BITCNT_EN: the bits_used port and counter are absent.

Structure
REQ-034 Package cw_pkg SHALL hold N_W=19, T_W=4, D_W=18, U_W=5 and the FSM state enum.
REQ-035 One sub-module, cw_idx_shreg: a u-bit MSB-first collector with load, shift, count-done and idx output.
REQ-036 The best-d stage is instantiated by the parent, not inside this block.

Verification
REQ-037 n=1024, t=2 (d=256, u=8), bits 1 -> n_q=768, t_q=2, no delta.
REQ-038 n=1024, t=2, bits 0,00000101 -> delta=5, n_q=1018, t_q=1.
REQ-039 n=4, t=4 -> four deltas of 0, then done=1, err=0.
REQ-040 t=0 start -> done two cycles later, no bit_ready, no delta.
REQ-041 delta_ready held low 5 cycles in EMIT -> delta stable, no bits consumed; rst in INDEX -> IDLE, outputs zero.
REQ-042 CW_ENC_BITCNT_EN build, case REQ-038 -> bits_used=9.
